// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: state encoding and a small state helper.
package mem_bus_arbiter_pkg;

    localparam int MEMARB_STATE_WD = 3;

    typedef enum logic [MEMARB_STATE_WD-1:0] {
        MA_IDLE    = 3'd0,
        MA_D_REQ   = 3'd1,
        MA_D_WAIT  = 3'd2,
        MA_I_REQ   = 3'd3,
        MA_I_WAIT  = 3'd4,
        MA_RELEASE = 3'd5
    } ma_state_e;

    function automatic logic ma_is_req(input ma_state_e s);
        return (s == MA_D_REQ) || (s == MA_I_REQ);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Serialises the core's fetch and data requests onto one SRAM-like bus, buffers read
// data, and stalls the pipeline until every request of the current core cycle is served.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// MA_IDLE    | pick next pending beat (data first when DATA_FIRST), or release
// MA_D_REQ   | data beat on the bus, waiting for addr_ok
// MA_D_WAIT  | data address accepted, waiting for data_ok
// MA_I_REQ   | fetch beat on the bus, waiting for addr_ok
// MA_I_WAIT  | fetch address accepted, waiting for data_ok
// MA_RELEASE | one cycle with the stall dropped so the pipeline advances
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_sram_en,
    input  logic [AW-1:0]   inst_sram_addr,
    output logic [DW-1:0]   inst_sram_rdata,

    input  logic            data_sram_en,
    input  logic [DW/8-1:0] data_sram_wen,
    input  logic [AW-1:0]   data_sram_addr,
    input  logic [DW-1:0]   data_sram_wdata,
    output logic [DW-1:0]   data_sram_rdata,

    output logic            stallreq_for_mem,

    output logic            bus_req,
    output logic            bus_wr,
    output logic [DW/8-1:0] bus_wstrb,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int SW = DW / 8;

    ma_state_e         state_q, state_d;
    logic              d_done_q, d_done_d;
    logic              i_done_q, i_done_d;
    logic [DW-1:0]     inst_rdata_q, inst_rdata_d;
    logic [DW-1:0]     data_rdata_q, data_rdata_d;
    logic              bus_wr_q, bus_wr_d;
    logic [SW-1:0]     bus_wstrb_q, bus_wstrb_d;
    logic [AW-1:0]     bus_addr_q, bus_addr_d;
    logic [DW-1:0]     bus_wdata_q, bus_wdata_d;

    logic              pend_d;
    logic              pend_i;

    assign pend_d = data_sram_en & ~d_done_q;
    assign pend_i = inst_sram_en & ~i_done_q;

    always_comb begin
        state_d      = state_q;
        d_done_d     = d_done_q;
        i_done_d     = i_done_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_wr_d     = bus_wr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        unique case (state_q)
            MA_IDLE: begin
                // Bus fields are latched on entry so they stay frozen for the whole beat
                // and simply hold afterwards.
                if (pend_d && (DATA_FIRST || !pend_i)) begin
                    state_d     = MA_D_REQ;
                    bus_wr_d    = |data_sram_wen;
                    bus_wstrb_d = data_sram_wen;
                    bus_addr_d  = data_sram_addr;
                    bus_wdata_d = data_sram_wdata;
                end else if (pend_i) begin
                    state_d     = MA_I_REQ;
                    bus_wr_d    = 1'b0;
                    bus_wstrb_d = '0;
                    bus_addr_d  = inst_sram_addr;
                end else if (d_done_q || i_done_q) begin
                    state_d = MA_RELEASE;
                end
            end
            MA_D_REQ: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        if (!bus_wr_q) data_rdata_d = bus_rdata;
                        d_done_d = 1'b1;
                        state_d  = MA_IDLE;
                    end else begin
                        state_d = MA_D_WAIT;
                    end
                end
            end
            MA_D_WAIT: begin
                if (bus_data_ok) begin
                    if (!bus_wr_q) data_rdata_d = bus_rdata;
                    d_done_d = 1'b1;
                    state_d  = MA_IDLE;
                end
            end
            MA_I_REQ: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        inst_rdata_d = bus_rdata;
                        i_done_d     = 1'b1;
                        state_d      = MA_IDLE;
                    end else begin
                        state_d = MA_I_WAIT;
                    end
                end
            end
            MA_I_WAIT: begin
                if (bus_data_ok) begin
                    inst_rdata_d = bus_rdata;
                    i_done_d     = 1'b1;
                    state_d      = MA_IDLE;
                end
            end
            MA_RELEASE: begin
                d_done_d = 1'b0;
                i_done_d = 1'b0;
                state_d  = MA_IDLE;
            end
            default: begin
                state_d = MA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= MA_IDLE;
            d_done_q     <= 1'b0;
            i_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            bus_wr_q     <= 1'b0;
            bus_wstrb_q  <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            d_done_q     <= d_done_d;
            i_done_q     <= i_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            bus_wr_q     <= bus_wr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign bus_req          = ma_is_req(state_q);
    assign bus_wr           = bus_wr_q;
    assign bus_wstrb        = bus_wstrb_q;
    assign bus_addr         = bus_addr_q;
    assign bus_wdata        = bus_wdata_q;
    assign inst_sram_rdata  = inst_rdata_q;
    assign data_sram_rdata  = data_rdata_q;
    assign stallreq_for_mem = (inst_sram_en | data_sram_en) & (state_q != MA_RELEASE);

endmodule
